mem_access_unit: RTL
====================

# mem_access_unit

Load/store sequencer in the memory stage of the RISC-V pipeline, between the EX/MEM pipeline register and the word-wide data memory. It converts RV32I byte/half/word loads and stores into word accesses on the memory's single-port interface (combinational read, write on clock edge, word write-enable only). It sign- or zero-extends load data. Sub-word stores run as a two-cycle read-modify-write, and the block stalls the pipeline for that extra cycle. Misaligned, out-of-range and illegal-funct3 requests are flagged and never touch memory.

## Interface
- DEPTH, 1024: memory depth in words. Word index = addr[31:2]; an index ≥ DEPTH is out of range.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  request present this cycle
- req_ready  out  1  block can accept; high only in IDLE with rst high
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  request was misaligned, out of range, or had illegal funct3
- mem_a  out  32  word index to memory: {2'b0, addr[31:2]}
- mem_wd  out  32  write data to memory
- mem_we  out  1  memory write enable
- mem_rd  in  32  memory read data (combinational from mem_a)

## Operation
- A request is accepted when req_valid && req_ready.
- States:
  - IDLE: accepts requests.
  - RMW_WR: second cycle of a sub-word store; req_ready = 0.
- Fault check on accept. Any one condition faults:
  - funct3 ∈ {3,6,7} for a load;
  - funct3 ∉ {0,1,2} for a store;
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - word index ≥ DEPTH.
- On a fault: mem_we = 0, stay in IDLE, rsp_valid/rsp_fault = 1 next cycle, rsp_rdata = 0.
- Load: in the accept cycle, mem_a comes combinationally from req_addr. The lane is selected from mem_rd by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. The result is registered.
- SW: in the accept cycle, mem_we = 1 and mem_wd = req_wdata. State stays IDLE.
- SB/SH:
  - Accept cycle: read the old word from mem_rd, merge req_wdata[7:0] or [15:0] into lane addr[1:0], and register the merged word and word index. mem_we = 0. Go to RMW_WR.
  - RMW_WR: drive mem_a from the registered index, mem_wd = merged word, mem_we = 1. Return to IDLE.
- mem_a, mem_wd and mem_we are 0 when neither IDLE-accept nor RMW_WR is driving them.

## Timing
- Reset (rst low at a clock edge):
  - state → IDLE; rsp_valid, rsp_fault, rsp_rdata, merge register → 0.
  - mem_we is gated to 0 combinationally whenever rst is low. An RMW_WR in progress is aborted with no write and no response.
  - req_ready = 0 while rst is low.
- Latency, accept cycle N to response:
  - load, SW, fault: rsp_valid in cycle N+1;
  - SB/SH: write edge ends cycle N+1, rsp_valid in cycle N+2.
- Back-to-back: a new request may be accepted in the same cycle as the previous rsp_valid pulse, except during RMW_WR.
- A load accepted the cycle after an SB/SH completes sees the merged word.
- Throughput: 1 request per cycle, except SB/SH at 1 per 2 cycles.
- req_valid while req_ready = 0: ignored. The upstream stage holds the request (stall = valid && !ready).

## Structure
- Package `mau_pkg`: funct3 localparams (F3_B/H/W/BU/HU), state enum {IDLE, RMW_WR}, lane-mask function.
- Sub-module `load_extend`: combinational; inputs word, addr[1:0], funct3; output 32-bit extended data. Instantiated once.
- FSM, fault checks, merge register and memory muxing live in the top module.

## Test plan
- Reset mid-RMW: SB accepted, rst low in the RMW_WR cycle → mem_we never 1, word unchanged, no rsp_valid, req_ready = 0 until rst high.
- Word store then load: SW addr 0x10 data 0xDEADBEEF → mem_we in the accept cycle at mem_a = 4, rsp_valid next cycle. Then LW 0x10 → rsp_rdata 0xDEADBEEF.
- Byte loads and extension: word 4 = 0x80FF7F01.
  - LB 0x13 → 0xFFFFFF80;
  - LBU 0x13 → 0x00000080;
  - LH 0x12 → 0xFFFF80FF;
  - LHU 0x10 → 0x00007F01.
- Sub-word RMW: word 4 = 0x11223344.
  - SB 0x11 data 0xAB → req_ready low 1 cycle, word becomes 0x1122AB44, rsp_valid at N+2.
  - Then SH 0x12 data 0xCDEF → word 0xCDEFAB44.
- Faults, each giving rsp_fault = 1 next cycle and mem_we never asserted:
  - LW 0x12;
  - SH 0x13;
  - LW 0x1000 (index 1024 = DEPTH);
  - load funct3 = 3.
- Back-to-back streaming: LW, SW, LB on consecutive cycles → three rsp_valid pulses on consecutive cycles, req_ready constantly 1.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the memory-stage load/store sequencer.
// Contents: RV32I funct3 encodings, the FSM state type, and the store lane-mask helper.
// No logic of its own, so it has no latency or backpressure behaviour.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {IDLE, RMW_WR} state_t;

  // Byte-lane mask for a store of the given width that starts at byte offset 'lane'.
  function automatic logic [31:0] lane_mask(input logic [2:0] funct3, input logic [1:0] lane);
    logic [31:0] m;
    case (funct3)
      F3_B:    m = 32'h0000_00FF;
      F3_H:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte or half from a memory word, then sign- or zero-extends it.
// Ports: word (raw memory word), addr (byte offset in the word), funct3 (load type), data (extended result).
// The block is purely combinational, so it has zero latency and no backpressure.
module load_extend
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {addr, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:  data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:  data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:  data = word;
      F3_BU: data = {24'h0, shifted[7:0]};
      F3_HU: data = {16'h0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Turns RV32I loads and stores into word accesses on a single-port memory. Sub-word stores are done as read-modify-write.
// Ports: req_* carries the pipeline request, rsp_* is the one-cycle response, and mem_* is the word memory (combinational read).
// Latency is N+1 for loads, SW and faults, and N+2 for SB/SH. req_ready drops during the RMW write cycle and while in reset.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  state_t      state;
  logic [29:0] idx_q;
  logic [31:0] merged_q;

  logic        accept;
  logic        fault;
  logic        f3_bad;
  logic        misalign;
  logic        oor;
  logic        go;
  logic        store_word;
  logic [31:0] word_idx;
  logic [31:0] mask;
  logic [31:0] wdata_sh;
  logic [31:0] merged;
  logic [31:0] load_data;

  assign req_ready = rst && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    word_idx = {2'b00, req_addr[31:2]};
    f3_bad   = req_write ? (req_funct3 > F3_W)
                         : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    // funct3[1:0] gives the access size for every legal encoding (0 byte, 1 half, 2 word).
    misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    oor      = word_idx >= DEPTH;
    fault    = f3_bad || misalign || oor;
    go       = accept && !fault;
    store_word = go && req_write && (req_funct3 == F3_W);
  end

  // Merge the new byte or half into the old word that is being read this cycle.
  always_comb begin
    mask     = lane_mask(req_funct3, req_addr[1:0]);
    wdata_sh = req_wdata << {req_addr[1:0], 3'b000};
    merged   = (mem_rd & ~mask) | (wdata_sh & mask);
  end

  load_extend u_load_extend (
    .word   (mem_rd),
    .addr   (req_addr[1:0]),
    .funct3 (req_funct3),
    .data   (load_data)
  );

  // Memory port mux. Reset gates only the write enable, so an RMW in flight is dropped without a write.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (state == RMW_WR) begin
      mem_a  = {2'b00, idx_q};
      mem_wd = merged_q;
      mem_we = rst;
    end else if (go) begin
      mem_a = word_idx;
      if (store_word) begin
        mem_wd = req_wdata;
        mem_we = rst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      merged_q  <= '0;
      idx_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
            end else if (!req_write) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= load_data;
            end else if (req_funct3 == F3_W) begin
              rsp_valid <= 1'b1;
            end else begin
              merged_q <= merged;
              idx_q    <= req_addr[31:2];
              state    <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
